sdf_reorder_buffer: RTL and testbench
=====================================

# sdf_reorder_buffer

Parametrised ping-pong reorder buffer between the `sdf_top` NTT/INTT pipeline output and the AXI wrapper's output stream. It accepts coefficients in the scrambled order produced by the SDF stages, tagged with `out_address` and qualified by `data_valid`. Complete frames are re-emitted in natural index order over a valid/ready stream. Two banks let one frame drain while the next one fills, so the in-bench address-scatter capture becomes a synthesisable block.

## Interface
Parameters:
- `data_width`, 32, coefficient width in bits.
- `address_width`, 4, log2 of the polynomial size; N = 2**address_width.

Ports:
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  data_width  coefficient from `sdf_out`.
- `in_address`  in  address_width  destination index from `out_address`.
- `in_valid`  in  1  input qualifier, from `data_valid`.
- `in_ready`  out  1  buffer can accept a write this cycle.
- `out_data`  out  data_width  coefficient at natural index `out_index`.
- `out_index`  out  address_width  index of the word currently presented.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_last`  out  1  marks index N-1 of a frame.
- `frame_done`  out  1  one-cycle tick after the last output handshake of a frame.
- `err_dup`  out  1  sticky; an address was written twice within one frame.
- `err_ovf`  out  1  sticky; `in_valid` was asserted while `in_ready` was low.
- `busy`  out  1  at least one bank is filling or full.

## Operation
- Storage: two banks, each N × data_width. Per-bank state: `written` mask (N bits) and `full` flag. Pointers: `wbank` and `rbank`. Read index: `rd_idx`.
- Write path:
  - Accept when `in_valid && in_ready`, with `in_ready = !full[wbank]`.
  - Data goes to `bank[wbank][in_address]` and sets `written[wbank][in_address]`.
  - If that mask bit was already set, the data is overwritten and `err_dup` is set. The fill count does not advance.
  - When the mask becomes all ones, set `full[wbank]`, clear the mask, and toggle `wbank`.
- Read path:
  - `out_valid = full[rbank]`.
  - `out_data = bank[rbank][rd_idx]`, `out_index = rd_idx`, `out_last = out_valid && rd_idx == N-1`.
  - On each handshake, `rd_idx` increments.
  - On the handshake with `out_last`: clear `full[rbank]`, toggle `rbank`, wrap `rd_idx` to 0, and pulse `frame_done` on the next cycle.
- Dropped writes: a write attempted while `in_ready` is low is dropped and sets `err_ovf`.
- `busy` = `full[0] | full[1] | (|written[wbank])`.
- Sticky errors clear only on reset.

## Timing
- Reset values:
  - Outputs: `in_ready`=1; `out_valid`, `out_last`, `frame_done`, `err_dup`, `err_ovf`, `busy` = 0; `out_index` = 0.
  - Internal state: `wbank` = `rbank` = 0; `rd_idx` = 0; all masks and full flags cleared.
  - Bank data contents are not reset.
- Latency: if the final write of a frame is accepted at edge k, `out_valid` is high after edge k, i.e. in cycle k+1. Index 0 is presented in that same cycle.
- Throughput: one word per cycle on each side; reading is combinational from the register array.
- Simultaneous completion and release: a bank completing on the write side in the same cycle the other bank is released on the read side is legal. Both updates apply; nothing is lost.
- Both banks full: `in_ready` is low. It returns high the cycle after the releasing `out_last` handshake, not in the same cycle.
- `out_ready` low holds `out_data`, `out_index` and `out_last` stable.
- Reset mid-frame: partial frames and pending output are discarded. Outputs return to reset values asynchronously.

## Configuration
- `SDF_REORDER_BITREV_EN`:
  - Defined: the write index is the bit-reverse of `in_address`. Use this when the SDF emits natural-counter addresses for bit-reversed data.
  - Undefined: `in_address` is used directly.
  - Affects only the write index; the read side is unaffected.

## Test plan
1. N=16, write addresses 15..0 with data = 100+address, `out_ready`=1 → `out_valid` in the cycle after the 16th write. Outputs 100..115 in index order, `out_last` at index 15, `frame_done` one cycle later.
2. Two frames back-to-back (data 0x10+i, then 0x20+i), `out_ready` low for 40 cycles → `in_ready` drops after the 32nd write. Frame 1 drains fully before frame 2. A 33rd write is dropped and sets `err_ovf`.
3. Address 3 written twice (data 7, then 9) and address 5 never written → no `out_valid`, `err_dup`=1. A later write to address 5 completes the frame, and index 3 reads 9.
4. `out_ready` toggled every cycle on a full frame → each word held until accepted; 16 handshakes in total, no duplicated or skipped index.
5. Assert `rst_n`=0 after 7 writes → all outputs at reset values. A subsequent full frame reads back correctly from bank 0.
6. With `SDF_REORDER_BITREV_EN` defined, write `in_address` 1 with data 0xAA → the word appears at `out_index` 8.

Source files
------------

// File: rtl/sdf_reorder_buffer.sv
// rtl/sdf_reorder_buffer.sv - ping-pong reorder buffer: scattered SDF writes in, natural-order frames out
// Optional feature macro: SDF_REORDER_BITREV_EN (bit-reverse the write index).
module sdf_reorder_buffer #(
    parameter int data_width    = 32,
    parameter int address_width = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [data_width-1:0]    in_data,
    input  logic [address_width-1:0] in_address,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [data_width-1:0]    out_data,
    output logic [address_width-1:0] out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     err_dup,
    output logic                     err_ovf,
    output logic                     busy
);
    localparam int n = 1 << address_width;

    logic [data_width-1:0]    mem [0:2*n-1];
    logic [n-1:0]             written [2];
    logic [1:0]               full;
    logic                     wbank;
    logic                     rbank;
    logic [address_width-1:0] rd_idx;
    logic                     frame_done_q;
    logic                     err_dup_q;
    logic                     err_ovf_q;

    logic [address_width-1:0] wr_idx;
    logic [n-1:0]             mask_next;
    logic                     wr_fire;
    logic                     wr_dup;
    logic                     wr_complete;
    logic                     rd_fire;
    logic                     rd_done;

    always_comb begin
        wr_idx = in_address;
`ifdef SDF_REORDER_BITREV_EN
        for (int i = 0; i < address_width; i++) begin
            wr_idx[i] = in_address[address_width-1-i];
        end
`endif
    end

    assign in_ready    = !full[wbank];
    assign wr_fire     = in_valid && in_ready;
    assign wr_dup      = written[wbank][wr_idx];
    assign mask_next   = written[wbank] | ({{(n-1){1'b0}}, 1'b1} << wr_idx);
    // A duplicate cannot complete a frame: its bit was already in the mask.
    assign wr_complete = wr_fire && !wr_dup && (&mask_next);

    assign out_valid  = full[rbank];
    assign out_index  = rd_idx;
    assign out_data   = mem[{rbank, rd_idx}];
    assign out_last   = out_valid && (rd_idx == address_width'(n-1));
    assign rd_fire    = out_valid && out_ready;
    assign rd_done    = rd_fire && out_last;

    assign frame_done = frame_done_q;
    assign err_dup    = err_dup_q;
    assign err_ovf    = err_ovf_q;
    assign busy       = full[0] | full[1] | (|written[wbank]);

    // Bank storage carries no reset; validity is tracked by the masks and full flags.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wbank, wr_idx}] <= in_data;
        end
    end

    // Write completion and read release always target different banks, so both may apply together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written[0]   <= '0;
            written[1]   <= '0;
            full         <= '0;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            rd_idx       <= '0;
            frame_done_q <= 1'b0;
            err_dup_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_complete) begin
                    full[wbank]    <= 1'b1;
                    written[wbank] <= '0;
                    wbank          <= ~wbank;
                end else begin
                    written[wbank] <= mask_next;
                end
                if (wr_dup) begin
                    err_dup_q <= 1'b1;
                end
            end
            if (in_valid && !in_ready) begin
                err_ovf_q <= 1'b1;
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_done) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
            frame_done_q <= rd_done;
        end
    end
endmodule

// File: tb/tb_sdf_reorder_buffer.sv
// tb/tb_sdf_reorder_buffer.sv - scoreboard testbench for sdf_reorder_buffer
module tb_sdf_reorder_buffer;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk_tb;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_address;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic          err_dup;
    logic          err_ovf;
    logic          busy;

    sdf_reorder_buffer #(.data_width(DW), .address_width(AW)) dut (
        .clk        (clk_tb),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_address (in_address),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .err_dup    (err_dup),
        .err_ovf    (err_ovf),
        .busy       (busy)
    );

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] frame_exp [N];
    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;

    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_i;
    logic          hold_l;
    logic          exp_fd = 1'b0;

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid   = 1'b1;
        in_address = a;
        in_data    = d;
        @(posedge clk_tb);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            sb.push_back('{idx: AW'(i), data: frame_exp[i], last: (i == N-1)});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            @(posedge clk_tb);
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
        @(posedge clk_tb);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   64'(in_ready),   64'd1);
        chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
        chk({tag, "_out_last"},   64'(out_last),   64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_err_dup"},    64'(err_dup),    64'd0);
        chk({tag, "_err_ovf"},    64'(err_ovf),    64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_out_index"},  64'(out_index),  64'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks hold stability and frame_done.
    always @(negedge clk_tb) begin
        if (!rst_n) begin
            hold_v = 1'b0;
            exp_fd = 1'b0;
        end else begin
            chk("frame_done", 64'(frame_done), 64'(exp_fd));
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data",  64'(out_data),  64'(hold_d));
                chk("hold_index", 64'(out_index), 64'(hold_i));
                chk("hold_last",  64'(out_last),  64'(hold_l));
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid actual index=%0d data=%0h expected no output", out_index, out_data);
                end else if (out_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    hs_cnt++;
                    chk("out_index", 64'(out_index), 64'(e.idx));
                    chk("out_data",  64'(out_data),  64'(e.data));
                    chk("out_last",  64'(out_last),  64'(e.last));
                end
            end
            exp_fd = out_valid && out_ready && out_last;
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_index;
            hold_l = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int hs_start;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_address = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk_tb);
        #1;
        rst_n = 1'b1;

        // 1: reverse-order addresses, data 100+address
        out_ready = 1'b1;
        for (int a = N-1; a >= 0; a--) begin
            wr(AW'(a), DW'(100 + a));
            frame_exp[a] = DW'(100 + a);
            if (a == N-1) chk("t1_busy_partial", 64'(busy), 64'd1);
            if (a == 1)   chk("t1_valid_before_last", 64'(out_valid), 64'd0);
        end
        chk("t1_valid_latency", 64'(out_valid), 64'd1);
        chk("t1_first_index",   64'(out_index), 64'd0);
        chk("t1_first_data",    64'(out_data),  64'd100);
        push_frame();
        drain();
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // 2: two frames with output stalled, then an overflow write
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) begin
                wr(AW'(i), DW'(32'h10 * (f + 1) + i));
                frame_exp[i] = DW'(32'h10 * (f + 1) + i);
            end
            push_frame();
            if (f == 0) chk("t2_ready_after_16", 64'(in_ready), 64'd1);
        end
        chk("t2_ready_after_32", 64'(in_ready), 64'd0);
        chk("t2_ovf_before",     64'(err_ovf),  64'd0);
        wr(AW'(0), DW'(32'hDEAD));
        chk("t2_ovf_after", 64'(err_ovf), 64'd1);
        repeat (40) @(posedge clk_tb);
        #1;
        out_ready = 1'b1;
        drain();
        chk("t2_ready_restored", 64'(in_ready), 64'd1);

        // 3: duplicate address 3, address 5 missing until the end
        for (int i = 0; i < N; i++) begin
            if (i != 5) wr(AW'(i), (i == 3) ? DW'(7) : DW'(32'h30 + i));
            frame_exp[i] = DW'(32'h30 + i);
        end
        wr(AW'(3), DW'(9));
        frame_exp[3] = DW'(9);
        repeat (5) @(posedge clk_tb);
        #1;
        chk("t3_no_valid", 64'(out_valid), 64'd0);
        chk("t3_err_dup",  64'(err_dup),   64'd1);
        chk("t3_busy",     64'(busy),      64'd1);
        wr(AW'(5), DW'(32'h35));
        chk("t3_valid_on_complete", 64'(out_valid), 64'd1);
        push_frame();
        drain();

        // 4: out_ready toggling every cycle
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr(AW'(i), DW'(32'h1111 * (i + 1)));
            frame_exp[i] = DW'(32'h1111 * (i + 1));
        end
        push_frame();
        hs_start = hs_cnt;
        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            out_ready = ~out_ready;
            @(posedge clk_tb);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("t4_handshakes", 64'(hs_cnt - hs_start), 64'd16);

        // 5: reset mid-frame, then a clean frame
        for (int i = 0; i < 7; i++) wr(AW'(i), DW'(32'hBAD0 + i));
        chk("t5_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_reset");
        @(posedge clk_tb);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr(AW'((i * 5) % N), DW'(32'h5000 + (i * 5) % N));
            frame_exp[(i * 5) % N] = DW'(32'h5000 + (i * 5) % N);
        end
        push_frame();
        drain();

`ifdef SDF_REORDER_BITREV_EN
        // 6: bit-reversed write index, address 1 lands at index 8
        for (int a = 0; a < N; a++) begin
            logic [AW-1:0] av;
            logic [AW-1:0] rv;
            av = AW'(a);
            for (int b = 0; b < AW; b++) rv[b] = av[AW-1-b];
            wr(av, (a == 1) ? DW'(32'hAA) : DW'(32'h600 + a));
            frame_exp[rv] = (a == 1) ? DW'(32'hAA) : DW'(32'h600 + a);
        end
        chk("t6_index8_data_model", 64'(frame_exp[8]), 64'hAA);
        push_frame();
        drain();
`endif

        repeat (3) @(posedge clk_tb);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
